// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state, cause and width definitions for the reset sequencer
package reset_seq_pkg;
  typedef enum logic [1:0] {HOLD, RELEASE, RUN} seq_state_t;
  typedef enum logic [1:0] {CAUSE_XRES = 2'd0, CAUSE_SW = 2'd1, CAUSE_WDT = 2'd2} rst_cause_t;
  localparam int RST_COUNT_W = 8;
endpackage

// File: rtl/wdt_counter.sv
// wdt_counter: watchdog that flags a timeout after TIMEOUT un-kicked enabled cycles
module wdt_counter #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic kick,
  output logic timeout
);
  localparam int W = $clog2(TIMEOUT) + 1;
  logic [W-1:0] cnt_q, cnt_d;
  // count while enabled, clear on kick or disable, stick at the terminal value
  always_comb begin
    timeout = en && !kick && cnt_q == W'(TIMEOUT - 1);
    cnt_d = (!en || kick) ? '0 : (cnt_q == W'(TIMEOUT - 1) ? cnt_q : cnt_q + W'(1));
  end
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged multi-domain reset release with software and watchdog restart
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS      = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int WDT_TIMEOUT    = 1024
) (
  input  logic                   XCLK,
  input  logic                   XRES,
  input  logic                   SWRST,
  input  logic                   WDT_EN,
  input  logic                   WDT_KICK,
  output logic [N_DOMAINS-1:0]   RST_OUT,
  output logic                   READY,
  output logic [1:0]             CAUSE,
  output logic [RST_COUNT_W-1:0] RST_COUNT
);
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int SW = $clog2(STAGGER_CYCLES > 0 ? STAGGER_CYCLES : 1) + 1;
  localparam int STG_LAST = STAGGER_CYCLES > 0 ? STAGGER_CYCLES - 1 : 0;
  localparam bit ALL_AT_ONCE = STAGGER_CYCLES == 0 || N_DOMAINS == 1;
  localparam logic [N_DOMAINS-1:0] ONE = N_DOMAINS'(1);
  seq_state_t state_q, state_d;
  rst_cause_t cause_q, cause_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [SW-1:0] stg_q, stg_d;
  logic [N_DOMAINS-1:0] rst_q, rst_d, rel_mask;
  logic [RST_COUNT_W-1:0] cnt_q, cnt_d;
  logic ready_q, ready_d, timeout, restart;
  wdt_counter #(.TIMEOUT(WDT_TIMEOUT)) u_wdt (
    .clk(XCLK),
    .rst(XRES),
    .en(state_q == RUN && WDT_EN),
    .kick(WDT_KICK),
    .timeout(timeout)
  );
  // next state: restart overrides everything, else hold count, staggered release, run
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    stg_d = stg_q;
    rst_d = rst_q;
    ready_d = ready_q;
    cause_d = cause_q;
    cnt_d = cnt_q;
    restart = SWRST || timeout;
    rel_mask = rst_q & (rst_q - ONE);
    if (restart) begin
      state_d = HOLD;
      hold_d = '0;
      stg_d = '0;
      rst_d = '1;
      ready_d = 1'b0;
      cause_d = SWRST ? CAUSE_SW : CAUSE_WDT;
      cnt_d = cnt_q + RST_COUNT_W'(cnt_q != '1);
    end else begin
      unique case (state_q)
        HOLD: begin
          if (hold_q == HW'(HOLD_CYCLES - 1)) begin
            rst_d = ALL_AT_ONCE ? '0 : rel_mask;
            stg_d = '0;
            state_d = ALL_AT_ONCE ? RUN : RELEASE;
            ready_d = ALL_AT_ONCE;
          end else hold_d = hold_q + HW'(1);
        end
        RELEASE: begin
          if (stg_q == SW'(STG_LAST)) begin
            rst_d = rel_mask;
            stg_d = '0;
            state_d = rel_mask == '0 ? RUN : RELEASE;
            ready_d = rel_mask == '0;
          end else stg_d = stg_q + SW'(1);
        end
        RUN: state_d = RUN;
        default: state_d = HOLD;
      endcase
    end
  end
  // state and output registers
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      state_q <= HOLD;
      hold_q <= '0;
      stg_q <= '0;
      rst_q <= '1;
      ready_q <= 1'b0;
      cause_q <= CAUSE_XRES;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      stg_q <= stg_d;
      rst_q <= rst_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
      cnt_q <= cnt_d;
    end
  end
  assign RST_OUT = rst_q;
  assign READY = ready_q;
  assign CAUSE = cause_q;
  assign RST_COUNT = cnt_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of staged release, restarts, watchdog and saturation
module tb_reset_sequencer;
  logic XCLK = 1'b0, XRES = 1'b1, SWRST = 1'b0, WDT_EN = 1'b0, WDT_KICK = 1'b0;
  logic [3:0] rst_out;
  logic ready;
  logic [1:0] cause;
  logic [7:0] rst_count;
  logic [0:0] rst2;
  logic ready2;
  logic [1:0] cause2;
  logic [7:0] count2;
  int n_cmp = 0, n_fail = 0;
  int seq_edge[8] = '{15, 16, 19, 20, 23, 24, 27, 28};
  logic [3:0] seq_rst[8] = '{4'b1111, 4'b1110, 4'b1110, 4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b0000};
  logic seq_rdy[8] = '{0, 0, 0, 0, 0, 0, 0, 1};

  reset_sequencer #(.N_DOMAINS(4), .HOLD_CYCLES(16), .STAGGER_CYCLES(4), .WDT_TIMEOUT(8)) dut (
    .XCLK(XCLK), .XRES(XRES), .SWRST(SWRST), .WDT_EN(WDT_EN), .WDT_KICK(WDT_KICK),
    .RST_OUT(rst_out), .READY(ready), .CAUSE(cause), .RST_COUNT(rst_count)
  );
  reset_sequencer #(.N_DOMAINS(1), .HOLD_CYCLES(5), .STAGGER_CYCLES(0), .WDT_TIMEOUT(8)) dut2 (
    .XCLK(XCLK), .XRES(XRES), .SWRST(SWRST), .WDT_EN(WDT_EN), .WDT_KICK(WDT_KICK),
    .RST_OUT(rst2), .READY(ready2), .CAUSE(cause2), .RST_COUNT(count2)
  );

  always #5 XCLK = ~XCLK;

  task automatic step(input int n = 1);
    repeat (n) @(posedge XCLK);
    #1;
  endtask

  task automatic test_reset;
    XRES = 1'b1;
    step(3);
    n_cmp++;
    if (rst_out !== 4'b1111 || ready !== 1'b0 || cause !== 2'd0 || rst_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset: got rst=%b rdy=%b cause=%0d cnt=%0d want 1111/0/0/0", rst_out, ready, cause, rst_count);
    end
    XRES = 1'b0;
  endtask

  task automatic test_power_on;
    for (int k = 1; k <= 28; k++) begin
      step();
      for (int j = 0; j < 8; j++)
        if (seq_edge[j] == k) begin
          n_cmp++;
          if (rst_out !== seq_rst[j] || ready !== seq_rdy[j]) begin
            n_fail++;
            $display("FAIL power_on edge %0d: got rst=%b rdy=%b want rst=%b rdy=%b", k, rst_out, ready, seq_rst[j], seq_rdy[j]);
          end
        end
    end
    n_cmp++;
    if (cause !== 2'd0) begin
      n_fail++;
      $display("FAIL power_on cause: got %0d want 0", cause);
    end
  endtask

  task automatic test_sw_reset;
    SWRST = 1'b1;
    step();
    SWRST = 1'b0;
    n_cmp++;
    if (rst_out !== 4'b1111 || ready !== 1'b0 || cause !== 2'd1 || rst_count !== 8'd1) begin
      n_fail++;
      $display("FAIL sw_reset: got rst=%b rdy=%b cause=%0d cnt=%0d want 1111/0/1/1", rst_out, ready, cause, rst_count);
    end
    for (int k = 1; k <= 28; k++) begin
      step();
      for (int j = 0; j < 8; j++)
        if (seq_edge[j] == k) begin
          n_cmp++;
          if (rst_out !== seq_rst[j] || ready !== seq_rdy[j]) begin
            n_fail++;
            $display("FAIL sw_seq edge %0d: got rst=%b rdy=%b want rst=%b rdy=%b", k, rst_out, ready, seq_rst[j], seq_rdy[j]);
          end
        end
    end
  endtask

  task automatic test_watchdog;
    logic saw_reset;
    WDT_EN = 1'b1;
    step(7);
    n_cmp++;
    if (rst_out !== 4'b0000 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wdt_early: got rst=%b rdy=%b want 0000/1", rst_out, ready);
    end
    step();
    n_cmp++;
    if (rst_out !== 4'b1111 || cause !== 2'd2 || rst_count !== 8'd2) begin
      n_fail++;
      $display("FAIL wdt_fire: got rst=%b cause=%0d cnt=%0d want 1111/2/2", rst_out, cause, rst_count);
    end
    step(28);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wdt_resequence: got rdy=%b want 1", ready);
    end
    saw_reset = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      WDT_KICK = (i % 7 == 0);
      step();
      if (!ready) saw_reset = 1'b1;
    end
    WDT_KICK = 1'b0;
    n_cmp++;
    if (saw_reset !== 1'b0 || rst_count !== 8'd2) begin
      n_fail++;
      $display("FAIL wdt_kicked: got reset_seen=%b cnt=%0d want 0/2", saw_reset, rst_count);
    end
  endtask

  task automatic test_simultaneous;
    WDT_EN = 1'b0;
    step();
    WDT_EN = 1'b1;
    step(7);
    SWRST = 1'b1;
    step();
    SWRST = 1'b0;
    n_cmp++;
    if (rst_out !== 4'b1111 || cause !== 2'd1 || rst_count !== 8'd3) begin
      n_fail++;
      $display("FAIL sw_on_timeout: got rst=%b cause=%0d cnt=%0d want 1111/1/3", rst_out, cause, rst_count);
    end
    step(28);
    WDT_EN = 1'b0;
    step();
    WDT_EN = 1'b1;
    step(7);
    WDT_KICK = 1'b1;
    step();
    WDT_KICK = 1'b0;
    n_cmp++;
    if (rst_out !== 4'b0000 || ready !== 1'b1 || rst_count !== 8'd3) begin
      n_fail++;
      $display("FAIL kick_on_timeout: got rst=%b rdy=%b cnt=%0d want 0000/1/3", rst_out, ready, rst_count);
    end
    step(7);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL kick_restart_count: got rdy=%b want 1", ready);
    end
    WDT_EN = 1'b0;
  endtask

  task automatic test_mid_restart;
    SWRST = 1'b1;
    step();
    SWRST = 1'b0;
    step(22);
    n_cmp++;
    if (rst_out !== 4'b1100 || rst_count !== 8'd4) begin
      n_fail++;
      $display("FAIL mid_before: got rst=%b cnt=%0d want 1100/4", rst_out, rst_count);
    end
    SWRST = 1'b1;
    step();
    SWRST = 1'b0;
    n_cmp++;
    if (rst_out !== 4'b1111 || rst_count !== 8'd5) begin
      n_fail++;
      $display("FAIL mid_restart: got rst=%b cnt=%0d want 1111/5", rst_out, rst_count);
    end
    step(15);
    n_cmp++;
    if (rst_out !== 4'b1111) begin
      n_fail++;
      $display("FAIL mid_hold: got rst=%b want 1111", rst_out);
    end
    step();
    n_cmp++;
    if (rst_out !== 4'b1110) begin
      n_fail++;
      $display("FAIL mid_release0: got rst=%b want 1110", rst_out);
    end
    step(12);
    n_cmp++;
    if (rst_out !== 4'b0000 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_done: got rst=%b rdy=%b want 0000/1", rst_out, ready);
    end
  endtask

  task automatic test_saturation;
    SWRST = 1'b1;
    step(10);
    SWRST = 1'b0;
    n_cmp++;
    if (rst_count !== 8'd15 || rst_out !== 4'b1111 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL swrst_held: got cnt=%0d rst=%b rdy=%b want 15/1111/0", rst_count, rst_out, ready);
    end
    repeat (300) begin
      SWRST = 1'b1;
      step();
      SWRST = 1'b0;
      step();
    end
    n_cmp++;
    if (rst_count !== 8'd255 || cause !== 2'd1) begin
      n_fail++;
      $display("FAIL saturate: got cnt=%0d cause=%0d want 255/1", rst_count, cause);
    end
  endtask

  task automatic test_xres_clears;
    XRES = 1'b1;
    step();
    n_cmp++;
    if (rst_count !== 8'd0 || cause !== 2'd0 || rst_out !== 4'b1111 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL xres_clear: got cnt=%0d cause=%0d rst=%b rdy=%b want 0/0/1111/0", rst_count, cause, rst_out, ready);
    end
    n_cmp++;
    if (rst2 !== 1'b1 || ready2 !== 1'b0 || count2 !== 8'd0 || cause2 !== 2'd0) begin
      n_fail++;
      $display("FAIL xres_clear_n1: got rst=%b rdy=%b cnt=%0d cause=%0d want 1/0/0/0", rst2, ready2, count2, cause2);
    end
    XRES = 1'b0;
  endtask

  task automatic test_edge_params;
    step(4);
    n_cmp++;
    if (rst2 !== 1'b1 || ready2 !== 1'b0) begin
      n_fail++;
      $display("FAIL n1_edge4: got rst=%b rdy=%b want 1/0", rst2, ready2);
    end
    step();
    n_cmp++;
    if (rst2 !== 1'b0 || ready2 !== 1'b1) begin
      n_fail++;
      $display("FAIL n1_edge5: got rst=%b rdy=%b want 0/1", rst2, ready2);
    end
    n_cmp++;
    if (rst_out !== 4'b1111) begin
      n_fail++;
      $display("FAIL n4_edge5: got rst=%b want 1111", rst_out);
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_sw_reset();
    test_watchdog();
    test_simultaneous();
    test_mid_restart();
    test_saturation();
    test_xres_clears();
    test_edge_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
